// File: rtl/md_pad_pkg.sv
// Shared definitions for the Mega Drive pad responder: button indices, phase
// type and the (th, phase, buttons) -> pressed-polarity pattern mapping.
package md_pad_pkg;

  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  localparam int PHASE_W = 2;
  typedef logic [PHASE_W-1:0] PHASE_T;

  // Returns [D5..D0] with 1 = pressed/asserted; the wire level is the inverse.
  function automatic logic [5:0] pad_pattern(input logic th,
                                             input PHASE_T phase,
                                             input logic [11:0] btn);
    logic [5:0] p;
    p = '0;
    if (th) begin
      if (phase == PHASE_T'(3))
        p = {btn[BTN_C], btn[BTN_B], btn[BTN_MODE], btn[BTN_X], btn[BTN_Y], btn[BTN_Z]};
      else
        p = {btn[BTN_C], btn[BTN_B], btn[BTN_R], btn[BTN_L], btn[BTN_D], btn[BTN_U]};
    end else begin
      case (phase)
        PHASE_T'(2): p = {btn[BTN_START], btn[BTN_A], 4'b1111};
        PHASE_T'(3): p = {btn[BTN_START], btn[BTN_A], 4'b0000};
        default:     p = {btn[BTN_START], btn[BTN_A], 2'b11, btn[BTN_D], btn[BTN_U]};
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/md_th_sync.sv
// Multi-flop synchronizer for the host TH line; idles high through reset and
// produces single-cycle rise/fall pulses on the synchronized level.
module md_th_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic th_i,
  output logic th_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   th_d_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      th_d_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], th_i};
      th_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign th_s_o = sync_q[SYNC_STAGES-1];
  assign rise_o = th_s_o & ~th_d_q;
  assign fall_o = ~th_s_o & th_d_q;

endmodule

// File: rtl/md6_pad_responder.sv
// Device side of the Mega Drive 3/6-button select protocol: tracks the TH
// multiplex phase with an idle timeout and drives the active-low data lines.
//   phase | meaning
//   0     | idle / first read: d-pad, B, C / Start, A, 3-button ID
//   1     | second read: same as phase 0
//   2     | third read: TH low shows the 6-button ID (D3..D0 low)
//   3     | extra read: TH high shows X/Y/Z/Mode, TH low shows D3..D0 high
module md6_pad_responder
  import md_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 60000,
  parameter int CNT_W       = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        six_button_en,
  input  logic [11:0] buttons,
  input  logic        th_in,
  output logic [5:0]  pad_out,
  output logic [1:0]  phase,
  output logic        timed_out,
  output logic        frame_read
);

  logic             th_s;
  logic             th_rise;
  logic             th_fall;

  PHASE_T           phase_q,     phase_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             timed_out_q, timed_out_d;
  logic             sel3_q,      sel3_d;
  logic [5:0]       pad_q;
  logic             frame_read_q;

  md_th_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_th_sync (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .th_i    (th_in),
    .th_s_o  (th_s),
    .rise_o  (th_rise),
    .fall_o  (th_fall)
  );

  // Any TH edge restarts the idle timer and beats an expiry in the same cycle.
  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    if (th_rise || th_fall) begin
      cnt_d       = '0;
      timed_out_d = 1'b0;
      if (th_rise) phase_d = PHASE_T'(phase_q + 1'b1);
    end else if (!timed_out_q) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        phase_d     = '0;
        timed_out_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (!six_button_en) phase_d = '0;
    sel3_d = ~th_s && (phase_d == PHASE_T'(3));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= '0;
      cnt_q        <= '0;
      timed_out_q  <= 1'b1;
      sel3_q       <= 1'b0;
      pad_q        <= 6'h3F;
      frame_read_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      timed_out_q  <= timed_out_d;
      sel3_q       <= sel3_d;
      pad_q        <= ~pad_pattern(th_s, phase_d, buttons);
      frame_read_q <= sel3_d & ~sel3_q;
    end
  end

  assign pad_out    = pad_q;
  assign phase      = phase_q;
  assign timed_out  = timed_out_q;
  assign frame_read = frame_read_q;

endmodule

// File: doc/md6_pad_responder.md
Name: md6_pad_responder

Overview:
- Emulates a Sega Mega Drive 3/6-button pad on the DB9 port: the device end of the select (TH) protocol that the DB9 reader drives via joy_mdsel.
- Samples the host's TH line, tracks the 6-button multiplex phase with a timeout, and drives six active-low data lines (D0..D5) from local button state.
- Sits next to the user-port mux in the top level.
- Used to feed a core's pad state out over SNAC, and as a loopback model for verifying the DB9 reader.

Parameters:
- SYNC_STAGES, 2, number of flops in the TH synchronizer (minimum 2).
- TIMEOUT_CYC, 60000, clk_sys cycles without a TH edge before the phase returns to 0 (1.5 ms at 40 MHz).
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk_sys  in  1  system clock (40 MHz nominal).
- reset_n  in  1  asynchronous active-low reset.
- six_button_en  in  1  1 = 6-button protocol, 0 = plain 3-button pad.
- buttons  in  12  active-high pressed flags: [0]R [1]L [2]D [3]U [4]A [5]B [6]C [7]Start [8]X [9]Y [10]Z [11]Mode.
- th_in  in  1  asynchronous select line from the host.
- pad_out  out  6  active-low lines D5..D0 toward the connector.
- phase  out  2  current multiplex phase, 0..3.
- timed_out  out  1  1 while idle after timeout (phase forced to 0, counter held).
- frame_read  out  1  one-cycle pulse on entry to phase 3 with TH low (complete 6-button read).

Behaviour:
- Reset values:
  - synchronizer flops = 1 (TH idles high); phase = 0; timeout counter = 0; timed_out = 1; frame_read = 0.
  - pad_out = 6'b111111 (nothing pressed, TH-high view).
- Synchronizer and edge detect: th_s is the last synchronizer stage, th_d is th_s delayed one cycle.
  - rise = th_s & ~th_d; fall = ~th_s & th_d.
- Phase counter:
  - On rise with six_button_en = 1: phase <= phase + 1, wrapping 3 -> 0.
  - With six_button_en = 0: phase is held at 0.
- Timeout counter:
  - Any edge (rise or fall) clears the counter and clears timed_out.
  - Otherwise, when not timed_out, the counter increments. On reaching TIMEOUT_CYC-1: phase <= 0, timed_out <= 1, and the counter holds.
  - An edge in the same cycle as expiry: the edge wins (phase increments from its current value; the counter clears).
- Output mux, registered. Values below are the pressed-polarity pattern [D5..D0]; pad_out is its bitwise inverse.
  - TH high, phase 0..2: {C, B, R, L, D, U}.
  - TH high, phase 3: {C, B, Mode, X, Y, Z}.
  - TH low, phase 0..1: {Start, A, 1, 1, D, U}. D3/D2 are forced low on the wire (the 3-button ID).
  - TH low, phase 2: {Start, A, 1, 1, 1, 1}. D3..D0 are all low on the wire (the 6-button ID).
  - TH low, phase 3: {Start, A, 0, 0, 0, 0}. D3..D0 are all high on the wire.
- Latency:
  - th_in change -> pad_out change = SYNC_STAGES + 1 cycles (3 by default).
  - buttons change -> pad_out change = 1 cycle.
- Phase update: phase updates in the same cycle that the rise is detected. The mux uses the new phase and th_s, so the first TH-high window after a rise already shows the incremented phase.
- frame_read: asserted for exactly one cycle, in the cycle the mux first selects (TH low, phase 3).
- six_button_en dropping mid-read: phase <= 0 next cycle; outputs revert to the 3-button patterns.
- reset_n asserted mid-read: all state returns to reset values asynchronously; pad_out reads 6'b111111 regardless of buttons until reset_n is released and one clk_sys edge has occurred.
- Button conflicts: none are filtered; U+D and L+R may both be pressed and are passed through.

Decomposition:
- Package md_pad_pkg holds:
  - button index constants (BTN_R .. BTN_MODE);
  - phase width / PHASE_T typedef;
  - a function mapping (th, phase, buttons) to the 6-bit pattern, shared with the DB9 reader's testbench model.
- Sub-module md_th_sync: SYNC_STAGES-deep synchronizer with reset-to-1 and rise/fall pulses. The block is otherwise flat.

Test Plan:
- Reset release, buttons=0, th_in=1 -> pad_out=6'h3F, phase=0, timed_out=1; three cycles after th_in=0 -> pad_out=6'h33.
- Buttons = A|Start|Up (12'h098), six_button_en=1, TH low/high cycles 1,2,3 (10 µs per level) -> patterns checked per Behaviour, then frame_read high one cycle:
  - TH-low phase-2 pad_out=6'h00;
  - TH-low phase-3 pad_out=6'h0F;
  - TH-high phase-3 pad_out=6'h3F (X/Y/Z/Mode unpressed).
- Buttons = X|Mode (12'h900), drive to phase 3, TH high -> pad_out=6'h33.
- Stop toggling TH after phase 2 -> at exactly TIMEOUT_CYC cycles after the last edge, phase=0 and timed_out=1; next TH-high read shows the phase-0 pattern.
- six_button_en=0, 8 TH toggles -> phase stays 0; TH low never yields 6'h00/6'h0F low nibble patterns, and frame_read never pulses.
- Assert reset_n low during phase 3, TH low, with buttons pressed -> pad_out=6'h3F immediately (asynchronously), phase=0; after release, normal 3-cycle response resumes.
